skein_key_schedule_store: RTL and testbench

- Write side of the Threefish-1024 key-word interface.
- Accepts the 16 key words and 2 tweak words of a block over a valid/ready stream.
- Computes the extended key parity word k16 and the third tweak word t2.
- Serves combinational reads: key words are indexed by the 5-bit key-word index that the subkey selection logic produces, (s+i) mod 17; tweak words are indexed by tweak number.
- Sits between the message/chaining-value loader and the subkey selection path.

---
 rtl/skein_key_schedule_store_pkg.sv | 21 ++
 rtl/skein_word_file_read_mux.sv | 17 +
 rtl/skein_key_schedule_store.sv | 109 ++++++++++
 tb/tb_skein_key_schedule_store.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skein_key_schedule_store_pkg.sv
// Shared constants and state encoding for the
// Threefish-1024 key/tweak word store.
package skein_key_schedule_store_pkg;

  localparam int WORD_W            = 64;
  localparam int NUM_KEY_WORDS     = 16;
  localparam int NUM_EXT_KEY_WORDS = 17;
  localparam int NUM_TWEAK_WORDS   = 3;

  localparam logic [WORD_W-1:0] KEY_PARITY =
    64'h1BD11BDAA9FC1A22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_TWEAK,
    ST_FINALIZE,
    ST_READY
  } state_t;

endpackage

// File: rtl/skein_word_file_read_mux.sv
// 17-entry word read mux; selects past the
// last entry read as zero.
module skein_word_file_read_mux
  import skein_key_schedule_store_pkg::*;
(
  input  logic [NUM_EXT_KEY_WORDS-1:0][WORD_W-1:0] words_i,
  input  logic [4:0]                               sel_i,
  output logic [WORD_W-1:0]                        word_o
);

  always_comb begin
    word_o = '0;
    if (sel_i < 5'(NUM_EXT_KEY_WORDS))
      word_o = words_i[sel_i];
  end

endmodule

// File: rtl/skein_key_schedule_store.sv
// Loads 16 key + 2 tweak words, derives k16 and t2,
// and serves combinational key/tweak reads.
module skein_key_schedule_store
  import skein_key_schedule_store_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic [63:0] word_i,
  output logic        schedule_valid_o,
  input  logic [4:0]  key_word_select_i,
  output logic [63:0] key_word_o,
  input  logic [1:0]  tweak_select_i,
  output logic [63:0] tweak_word_o
);

  state_t state_q, state_d;

  logic [NUM_EXT_KEY_WORDS-1:0][WORD_W-1:0] key_q;
  logic [NUM_TWEAK_WORDS-1:0][WORD_W-1:0]   tweak_q;
  logic [NUM_EXT_KEY_WORDS-1:0][WORD_W-1:0] tweak_file;
  logic [WORD_W-1:0] acc_q;
  logic [3:0]        cnt_q;
  logic              valid_q;
  logic              hs;

  assign word_ready_o = (state_q == ST_LOAD_KEY) ||
                        (state_q == ST_LOAD_TWEAK);
  assign hs = word_valid_i && word_ready_o;
  assign schedule_valid_o = valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_LOAD_KEY:
        if (hs && cnt_q == 4'd15) state_d = ST_LOAD_TWEAK;
      ST_LOAD_TWEAK:
        if (hs && cnt_q == 4'd1) state_d = ST_FINALIZE;
      ST_FINALIZE: state_d = ST_READY;
      ST_READY: ;
      default: state_d = ST_IDLE;
    endcase
    // A restart overrides whatever the load was doing
    if (start_i) state_d = ST_LOAD_KEY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_q   <= '0;
      tweak_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (start_i) begin
      key_q   <= '0;
      tweak_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD_KEY:
          if (hs) begin
            key_q[{1'b0, cnt_q}] <= word_i;
            acc_q <= acc_q ^ word_i;
            cnt_q <= cnt_q + 4'd1;
          end
        ST_LOAD_TWEAK:
          if (hs) begin
            tweak_q[{1'b0, cnt_q[0]}] <= word_i;
            cnt_q <= cnt_q[0] ? 4'd0 : 4'd1;
          end
        ST_FINALIZE: begin
          key_q[NUM_KEY_WORDS] <= KEY_PARITY ^ acc_q;
          tweak_q[2] <= tweak_q[0] ^ tweak_q[1];
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tweak_file = '0;
    for (int i = 0; i < NUM_TWEAK_WORDS; i++)
      tweak_file[i] = tweak_q[i];
  end

  skein_word_file_read_mux u_key_mux (
    .words_i (key_q),
    .sel_i   (key_word_select_i),
    .word_o  (key_word_o)
  );

  skein_word_file_read_mux u_tweak_mux (
    .words_i (tweak_file),
    .sel_i   ({3'b000, tweak_select_i}),
    .word_o  (tweak_word_o)
  );

endmodule

// File: tb/tb_skein_key_schedule_store.sv
// Directed bench for the key/tweak word store.
// Expected values are hand-computed constants.
module tb_skein_key_schedule_store;

  localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic        valid = 0;
  logic        ready;
  logic [63:0] word = '0;
  logic        sched_valid;
  logic [4:0]  ksel = '0;
  logic [63:0] kword;
  logic [1:0]  tsel = '0;
  logic [63:0] tword;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  skein_key_schedule_store dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .word_valid_i      (valid),
    .word_ready_o      (ready),
    .word_i            (word),
    .schedule_valid_o  (sched_valid),
    .key_word_select_i (ksel),
    .key_word_o        (kword),
    .tweak_select_i    (tsel),
    .tweak_word_o      (tword)
  );

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic send(input logic [63:0] w,
                      input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    word = w;
    valid = 1;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 valid = 0;
  endtask

  task automatic read_key(input int i,
                          output logic [63:0] v);
    ksel = 5'(i);
    #1 v = kword;
  endtask

  task automatic read_tweak(input int i,
                            output logic [63:0] v);
    tsel = 2'(i);
    #1 v = tword;
  endtask

  task automatic check_bitwalk(input string tag);
    logic [63:0] v;
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      read_key(i, v);
      if (v !== (64'd1 << i)) bad++;
    end
    check_eq({tag, "_keys"}, 64'(bad), 64'd0);
    read_key(16, v);
    check_eq({tag, "_k16"}, v, 64'h1BD11BDAA9FCE5DD);
    read_tweak(0, v);
    check_eq({tag, "_t0"}, v, 64'h1111111111111111);
    read_tweak(1, v);
    check_eq({tag, "_t1"}, v, 64'h2222222222222222);
    read_tweak(2, v);
    check_eq({tag, "_t2"}, v, 64'h3333333333333333);
  endtask

  task automatic load_bitwalk(input bit gaps);
    pulse_start();
    for (int i = 0; i < 16; i++)
      send(64'd1 << i, gaps ? int'($urandom_range(0, 3)) : 0);
    send(64'h1111111111111111, gaps ? 2 : 0);
    send(64'h2222222222222222, gaps ? 1 : 0);
  endtask

  initial begin
    logic [63:0] v;
    int bad;

    // Power-on reset, then abandon a partial load
    repeat (2) @(posedge clk);
    #1 rst = 0;
    pulse_start();
    for (int i = 0; i < 5; i++) send(64'hABCD0000 + 64'(i), 0);
    @(posedge clk);
    #3 rst = 1;
    #1;
    check_eq("rst_valid", 64'(sched_valid), 64'd0);
    check_eq("rst_ready", 64'(ready), 64'd0);
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      read_key(i, v);
      if (v !== 64'd0) bad++;
    end
    check_eq("rst_keys", 64'(bad), 64'd0);
    read_tweak(0, v);
    check_eq("rst_t0", v, 64'd0);
    @(negedge clk);
    rst = 0;
    check_eq("idle_ready", 64'(ready), 64'd0);

    // All-zero block
    pulse_start();
    for (int i = 0; i < 18; i++) send(64'd0, 0);
    check_eq("fin_valid", 64'(sched_valid), 64'd0);
    check_eq("fin_ready", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    check_eq("zero_valid", 64'(sched_valid), 64'd1);
    read_key(16, v);
    check_eq("zero_k16", v, C240);
    read_tweak(2, v);
    check_eq("zero_t2", v, 64'd0);

    // Bit-walk key without gaps
    load_bitwalk(0);
    @(posedge clk);
    #1;
    check_eq("bw_valid", 64'(sched_valid), 64'd1);
    check_bitwalk("bw");

    // Same block with valid gaps
    load_bitwalk(1);
    @(posedge clk);
    #1;
    check_eq("gap_valid", 64'(sched_valid), 64'd1);
    check_bitwalk("gap");

    // Words offered in READY are ignored
    @(negedge clk);
    check_eq("ready_rdy", 64'(ready), 64'd0);
    valid = 1;
    word = 64'hDEADBEEFDEADBEEF;
    repeat (3) @(posedge clk);
    #1 valid = 0;
    check_eq("ready_hold_v", 64'(sched_valid), 64'd1);
    check_bitwalk("hold");

    // Out-of-range reads
    read_key(17, v);
    check_eq("oor_k17", v, 64'd0);
    read_key(31, v);
    check_eq("oor_k31", v, 64'd0);
    read_tweak(3, v);
    check_eq("oor_t3", v, 64'd0);

    // Restart mid-load; the word on the start edge is dropped
    pulse_start();
    for (int i = 0; i < 7; i++) send(64'hAAAAAAAAAAAAAAAA, 0);
    @(negedge clk);
    start = 1;
    valid = 1;
    word = 64'h5555555555555555;
    @(posedge clk);
    #1;
    start = 0;
    valid = 0;
    check_eq("rs_valid", 64'(sched_valid), 64'd0);
    check_eq("rs_ready", 64'(ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      read_key(i, v);
      if (v !== 64'd0) bad++;
    end
    check_eq("rs_keys", 64'(bad), 64'd0);
    for (int i = 0; i < 16; i++) send(64'(i), 0);
    send(64'h5, 0);
    send(64'h9, 0);
    @(posedge clk);
    #1;
    check_eq("rs2_valid", 64'(sched_valid), 64'd1);
    read_key(0, v);
    check_eq("rs2_k0", v, 64'd0);
    read_key(7, v);
    check_eq("rs2_k7", v, 64'd7);
    read_key(15, v);
    check_eq("rs2_k15", v, 64'd15);
    read_key(16, v);
    check_eq("rs2_k16", v, C240);
    read_tweak(2, v);
    check_eq("rs2_t2", v, 64'hC);

    // Start during FINALIZE wins and clears everything
    pulse_start();
    for (int i = 0; i < 18; i++) send(64'hF, 0);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    check_eq("fs_valid", 64'(sched_valid), 64'd0);
    read_key(16, v);
    check_eq("fs_k16", v, 64'd0);
    read_tweak(2, v);
    check_eq("fs_t2", v, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
